ble_k_frac: RTL and testbench
=============================

BLE_K_FRAC -- requirements
Module: ble_k_frac

Interface
REQ-001 Parameter K, default 6, meaning LUT input count; legal range 4..6.
REQ-002 Parameter CFG_DW, default 8, meaning config-load word width; legal range 1..32.
REQ-003 Derived CFG_W = 2^K + 3 and NWORDS = ceil(CFG_W/CFG_DW); these SHALL be derived, not user-set.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ble_in  input  K  LUT inputs; ble_in[0] is the LSB of the LUT index.
REQ-007 ble_ce  input  2  per-FF clock enable; bit n enables FF n.
REQ-008 cfg_valid  input  1  config word valid.
REQ-009 cfg_data  input  CFG_DW  config word payload.
REQ-010 cfg_ready  output  1  block accepts a config word this cycle.
REQ-011 cfg_done  output  1  one-cycle pulse when a new config becomes active.
REQ-012 ble_out  output  2  BLE outputs 0 and 1.

Function
REQ-013 Config vector layout: bits [0 : 2^K-1] LUT truth table; bit 2^K frac; bit 2^K+1 omux0 select; bit 2^K+2 omux1 select.
REQ-014 Non-frac (frac=0): lut0 = lut1 = table[ble_in[K-1:0]].
REQ-015 Frac (frac=1): lut0 = table[ble_in[K-2:0]]; lut1 = table[2^(K-1) + ble_in[K-2:0]]; ble_in[K-1] is ignored.
REQ-016 FF n: Q <= lutn when ble_ce[n]=1, else holds; no other enable path.
REQ-017 ble_out[n] = lutn (combinational) when omux select n = 0, FFn Q when select = 1.
REQ-018 Loader FSM states IDLE, LOAD, COMMIT; cfg_ready = 1 in IDLE and LOAD, 0 in COMMIT.
REQ-019 Word accepted only when cfg_valid & cfg_ready; word w fills shadow bits [w*CFG_DW +: CFG_DW], word bit 0 -> lowest index.
REQ-020 IDLE->LOAD on accepting word 0 (if NWORDS=1, IDLE->COMMIT); LOAD->COMMIT on accepting word NWORDS-1; COMMIT->IDLE after one cycle.
REQ-021 Padding bits of the last word above CFG_W-1 SHALL be ignored.
REQ-022 In COMMIT, shadow copies to active config; cfg_done = 1 that same cycle; new config drives outputs from the next cycle.
REQ-023 Active config never changes except on COMMIT; partial loads never affect outputs.
REQ-024 cfg_valid during COMMIT is ignored (not accepted, no data loss flagged); sender must hold it.
REQ-025 Word counter resets to 0 on COMMIT entry; consecutive loads need no idle cycle beyond COMMIT.
REQ-026 FFs keep operating with the old config during LOAD.

Reset
REQ-027 reset clears FSM to IDLE, word counter, shadow, active config and both FF Qs to 0.
REQ-028 After reset: cfg_ready=1, cfg_done=0, ble_out=2'b00.
REQ-029 reset during LOAD or COMMIT aborts the load; no commit, no cfg_done pulse.
REQ-030 reset has priority over cfg_valid and ble_ce in the same cycle.

Structure
REQ-031 Shared package ble_pkg SHALL hold the loader-state enum, CFG_W/NWORDS helper functions and config bit-offset constants.
REQ-032 Loader (FSM, counter, shadow) SHALL be a sub-module ble_cfg_loader; LUT, FFs and omuxes stay in ble_k_frac.

Verification
REQ-033 K=6, CFG_DW=8: reset -> cfg_ready=1, cfg_done=0, ble_out=00 with any ble_in.
REQ-034 Load 9 words, table=64'hAAAA_AAAA_AAAA_AAAA, frac=0, sel=00 -> cfg_done pulses once, 1 cycle after word 8 accepted; ble_out[0]=ble_in[0] next cycle.
REQ-035 frac=1, lower half 32'hFFFF_0000, upper 32'h0000_FFFF, sel=00, ble_in=6'b110000 -> ble_out=2'b01; ble_in[5] toggles -> unchanged.
REQ-036 sel=11, ble_ce=2'b01, lut0=lut1=1 -> ble_out[0]=1 one cycle later, ble_out[1] stays 0.
REQ-037 Reset asserted after word 4 of 9 -> no cfg_done, outputs 0; fresh 9-word load then commits correctly.
REQ-038 cfg_valid held high across back-to-back loads -> ready low exactly one cycle per COMMIT, no word dropped or duplicated.

Source files
------------

// File: rtl/ble_pkg.sv
// ---------------------------------------------------------------------------
// ble_pkg
//
// Shared definitions for the fracturable K-input BLE and its config loader:
//   - ld_state_e    : loader FSM state encoding (IDLE / LOAD / COMMIT)
//   - cfg_width()   : config vector width for a given K (truth table + 3)
//   - cfg_nwords()  : number of CFG_DW-wide words needed to carry the vector
//   - tt_size()     : LUT truth-table size (2^K)
//   - *_bit()       : bit offsets of the control fields inside the vector
//
// Config vector layout (LSB first):
//   [0 .. 2^K-1]  LUT truth table
//   [2^K]         frac enable
//   [2^K+1]       output mux 0 select (0 = combinational, 1 = registered)
//   [2^K+2]       output mux 1 select
// ---------------------------------------------------------------------------
package ble_pkg;

    // Loader FSM states.
    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_LOAD   = 2'd1,
        LD_COMMIT = 2'd2
    } ld_state_e;

    // Legal parameter ranges for the BLE.
    localparam int K_MIN      = 4;
    localparam int K_MAX      = 6;
    localparam int CFG_DW_MIN = 1;
    localparam int CFG_DW_MAX = 32;

    // Number of truth-table entries for a K-input LUT.
    function automatic int tt_size(input int k);
        return 1 << k;
    endfunction

    // Full config vector width: truth table plus frac and two omux selects.
    function automatic int cfg_width(input int k);
        return tt_size(k) + 3;
    endfunction

    // Words of width dw needed to transport the config vector (ceiling).
    function automatic int cfg_nwords(input int k, input int dw);
        return (cfg_width(k) + dw - 1) / dw;
    endfunction

    // Bit offsets of the control fields that follow the truth table.
    function automatic int frac_bit(input int k);
        return tt_size(k);
    endfunction

    function automatic int omux0_bit(input int k);
        return tt_size(k) + 1;
    endfunction

    function automatic int omux1_bit(input int k);
        return tt_size(k) + 2;
    endfunction

endpackage : ble_pkg

// File: rtl/ble_cfg_loader.sv
// ---------------------------------------------------------------------------
// ble_cfg_loader
//
// Serial config loader for the BLE. Words arrive on a valid/ready handshake
// and are assembled into a shadow register; once the last word is taken the
// FSM spends exactly one COMMIT cycle copying shadow -> active and pulsing
// cfg_done_o. The active config therefore only ever changes as a whole, and
// a partially loaded shadow never reaches the logic it configures.
//
// Ports
//   clk          : clock, all state on rising edge
//   reset        : synchronous active-high reset (aborts any load in flight)
//   cfg_valid_i  : config word valid
//   cfg_data_i   : config word payload, word w lands at bits [w*CFG_DW +: CFG_DW]
//   cfg_ready_o  : word accepted this cycle if valid (low only in COMMIT)
//   cfg_done_o   : one-cycle pulse during COMMIT
//   active_cfg_o : currently active config vector
// ---------------------------------------------------------------------------
module ble_cfg_loader
    import ble_pkg::*;
#(
    parameter int K      = 6,
    parameter int CFG_DW = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_valid_i,
    input  logic [CFG_DW-1:0]       cfg_data_i,
    output logic                    cfg_ready_o,
    output logic                    cfg_done_o,
    output logic [cfg_width(K)-1:0] active_cfg_o
);

    localparam int CFG_W  = cfg_width(K);
    localparam int NWORDS = cfg_nwords(K, CFG_DW);
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

    ld_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] active_q;
    logic             accept;
    logic             last_word;

    assign cfg_ready_o = (state_q != LD_COMMIT);
    assign accept      = cfg_valid_i & cfg_ready_o;
    assign last_word   = (cnt_q == LAST_WORD);

    // The pulse is masked while reset is asserted so that a reset landing on
    // the COMMIT cycle aborts cleanly: no copy and no visible done.
    assign cfg_done_o   = (state_q == LD_COMMIT) & ~reset;
    assign active_cfg_o = active_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            LD_IDLE, LD_LOAD: begin
                if (accept) begin
                    if (last_word) begin
                        // Counter rewinds on COMMIT entry so the next load can
                        // start right after the single COMMIT cycle.
                        state_d = LD_COMMIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = LD_LOAD;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            LD_COMMIT: begin
                state_d = LD_IDLE;
            end
            default: begin
                state_d = LD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow write path: one slice per word. The last slice is truncated at
    // CFG_W, so padding bits of the final word are simply never stored.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
            localparam int LO    = gi * CFG_DW;
            localparam int HI    = ((LO + CFG_DW) < CFG_W) ? (LO + CFG_DW - 1) : (CFG_W - 1);
            localparam int WIDTH = HI - LO + 1;

            logic word_we;

            assign word_we         = accept && (cnt_q == CNT_W'(gi));
            assign shadow_d[HI:LO] = word_we ? cfg_data_i[WIDTH-1:0] : shadow_q[HI:LO];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LD_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            if (state_q == LD_COMMIT) begin
                active_q <= shadow_q;
            end
        end
    end

endmodule : ble_cfg_loader

// File: rtl/ble_k_frac.sv
// ---------------------------------------------------------------------------
// ble_k_frac
//
// Fracturable K-input basic logic element: one 2^K-entry LUT that can act as
// a single K-LUT (both outputs identical) or as two (K-1)-LUTs sharing the low
// K-1 inputs, each output followed by an enable FF and a comb/registered mux.
// Configuration arrives serially through ble_cfg_loader.
//
// Ports
//   clk       : clock, all state on rising edge
//   reset     : synchronous active-high reset
//   ble_in    : LUT inputs, ble_in[0] is the LSB of the LUT index
//   ble_ce    : per-FF clock enable, bit n enables FF n
//   cfg_valid : config word valid
//   cfg_data  : config word payload
//   cfg_ready : config word accepted this cycle if valid
//   cfg_done  : one-cycle pulse when a new config becomes active
//   ble_out   : BLE outputs 0 and 1
// ---------------------------------------------------------------------------
module ble_k_frac
    import ble_pkg::*;
#(
    parameter int K      = 6,
    parameter int CFG_DW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [K-1:0]      ble_in,
    input  logic [1:0]        ble_ce,
    input  logic              cfg_valid,
    input  logic [CFG_DW-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              cfg_done,
    output logic [1:0]        ble_out
);

    localparam int CFG_W     = cfg_width(K);
    localparam int TT        = tt_size(K);
    localparam int FRAC_BIT  = frac_bit(K);
    localparam int OMUX0_BIT = omux0_bit(K);
    localparam int OMUX1_BIT = omux1_bit(K);

    logic [CFG_W-1:0]    active_cfg;
    logic [TT-1:0]       lut_table;
    logic                frac_en;
    logic [1:0]          omux_sel;
    logic [1:0][K-1:0]   lut_idx;
    logic [1:0]          lut_out;
    logic [1:0]          ff_q, ff_d;

    // ------------------------------------------------------------------
    // Config loader
    // ------------------------------------------------------------------
    ble_cfg_loader #(
        .K      (K),
        .CFG_DW (CFG_DW)
    ) u_cfg_loader (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid_i  (cfg_valid),
        .cfg_data_i   (cfg_data),
        .cfg_ready_o  (cfg_ready),
        .cfg_done_o   (cfg_done),
        .active_cfg_o (active_cfg)
    );

    // ------------------------------------------------------------------
    // Config field decode
    // ------------------------------------------------------------------
    assign lut_table = active_cfg[TT-1:0];
    assign frac_en   = active_cfg[FRAC_BIT];
    assign omux_sel  = {active_cfg[OMUX1_BIT], active_cfg[OMUX0_BIT]};

    // In frac mode the top input is replaced by a constant half-select, so
    // output 0 reads the lower half of the table and output 1 the upper half.
    assign lut_idx[0] = frac_en ? {1'b0, ble_in[K-2:0]} : ble_in;
    assign lut_idx[1] = frac_en ? {1'b1, ble_in[K-2:0]} : ble_in;

    // ------------------------------------------------------------------
    // Per-output LUT read, enable FF and output mux
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_out
            assign lut_out[gi] = lut_table[lut_idx[gi]];
            assign ff_d[gi]    = ble_ce[gi] ? lut_out[gi] : ff_q[gi];
            assign ble_out[gi] = omux_sel[gi] ? ff_q[gi] : lut_out[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            ff_q <= '0;
        end else begin
            ff_q <= ff_d;
        end
    end

endmodule : ble_k_frac

// File: tb/tb_ble_k_frac.sv
// ---------------------------------------------------------------------------
// tb_ble_k_frac
//
// Directed bench for ble_k_frac at K=6, CFG_DW=8 (67-bit config, 9 words).
// Each config load prints one line; every comparison goes through check().
// ---------------------------------------------------------------------------
module tb_ble_k_frac;

    logic       clk;
    logic       reset;
    logic [5:0] ble_in;
    logic [1:0] ble_ce;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_ready;
    logic       cfg_done;
    logic [1:0] ble_out;

    int n_checks = 0;
    int n_fail   = 0;

    ble_k_frac #(
        .K      (6),
        .CFG_DW (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ble_in    (ble_in),
        .ble_ce    (ble_ce),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .ble_out   (ble_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {padding, omux1, omux0, frac, table}
    function automatic logic [71:0] mk_cfg(input logic [63:0] t, input logic frac,
                                           input logic [1:0] sel, input logic [4:0] pad);
        return {pad, sel[1], sel[0], frac, t};
    endfunction

    // Sends all 9 words with valid held, then checks the COMMIT cycle
    // (done high, ready low, outputs still from the old config) and the
    // cycle after it.
    task automatic load_cfg(input string tag, input logic [71:0] v, input logic [1:0] old_out);
        int n;
        cfg_valid = 1'b1;
        for (int w = 0; w < 9; w++) begin
            cfg_data = v[w*8 +: 8];
            n = 0;
            while (!cfg_ready && n < 8) begin
                tick();
                n++;
            end
            check({tag, "_ready"}, cfg_ready, 1);
            tick();
            if (w < 8) begin
                check({tag, "_no_early_done"}, cfg_done, 0);
                check({tag, "_partial_out"}, ble_out, old_out);
            end
        end
        cfg_valid = 1'b0;
        check({tag, "_commit_done"}, cfg_done, 1);
        check({tag, "_commit_ready"}, cfg_ready, 0);
        check({tag, "_commit_old_out"}, ble_out, old_out);
        tick();
        check({tag, "_post_done"}, cfg_done, 0);
        check({tag, "_post_ready"}, cfg_ready, 1);
        $display("load %s: committed cfg=%h", tag, v[66:0]);
    endtask

    logic [71:0] v_aaaa, v_frac, v_ones_ff, v_ones, v_cnt, cur;
    int          stalls, done_seen, n;

    initial begin
        v_aaaa    = mk_cfg(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 2'b00, 5'b11111);
        v_frac    = mk_cfg(64'h0000_FFFF_FFFF_0000, 1'b1, 2'b00, 5'b00000);
        v_ones_ff = mk_cfg(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b11, 5'b00000);
        v_ones    = mk_cfg(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b00, 5'b10101);
        v_cnt     = mk_cfg(64'h0123_4567_89AB_CDEF, 1'b0, 2'b00, 5'b00000);

        // ---- reset, with valid and enables asserted (reset wins) ----
        reset     = 1'b1;
        ble_in    = 6'h3F;
        ble_ce    = 2'b11;
        cfg_valid = 1'b1;
        cfg_data  = 8'hFF;
        tick();
        tick();
        check("rst_ready", cfg_ready, 1);
        check("rst_done", cfg_done, 0);
        check("rst_out", ble_out, 2'b00);
        reset     = 1'b0;
        cfg_valid = 1'b0;
        ble_ce    = 2'b00;
        tick();
        check("idle_out_3f", ble_out, 2'b00);
        ble_in = 6'h15;
        #1;
        check("idle_out_15", ble_out, 2'b00);
        check("idle_ready", cfg_ready, 1);

        // ---- non-frac table AAAA: output follows ble_in[0] ----
        ble_in = 6'b000001;
        load_cfg("aaaa", v_aaaa, 2'b00);
        check("aaaa_in01", ble_out, 2'b11);
        ble_in = 6'b101010;
        #1;
        check("aaaa_in2a", ble_out, 2'b00);
        ble_in = 6'b111111;
        #1;
        check("aaaa_in3f", ble_out, 2'b11);

        // ---- frac mode: halves selected, ble_in[5] ignored ----
        ble_in = 6'b110000;
        load_cfg("frac", v_frac, 2'b00);
        check("frac_in30", ble_out, 2'b01);
        ble_in = 6'b010000;
        #1;
        check("frac_in10", ble_out, 2'b01);
        ble_in = 6'b000001;
        #1;
        check("frac_in01", ble_out, 2'b10);

        // ---- registered outputs with per-FF enable ----
        load_cfg("ones_ff", v_ones_ff, 2'b10);
        check("ff_initial", ble_out, 2'b00);
        ble_ce = 2'b01;
        tick();
        ble_ce = 2'b00;
        check("ff_ce01", ble_out, 2'b01);
        tick();
        check("ff_hold", ble_out, 2'b01);
        ble_ce = 2'b10;
        tick();
        ble_ce = 2'b00;
        check("ff_ce10", ble_out, 2'b11);

        // ---- reset after word 4 of 9 aborts the load ----
        cfg_valid = 1'b1;
        for (int w = 0; w < 5; w++) begin
            cfg_data = v_aaaa[w*8 +: 8];
            tick();
        end
        cfg_valid = 1'b0;
        check("abort_partial_out", ble_out, 2'b11);
        check("abort_partial_done", cfg_done, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_rst_out", ble_out, 2'b00);
        check("abort_rst_done", cfg_done, 0);
        tick();
        check("abort_idle_done", cfg_done, 0);
        check("abort_idle_ready", cfg_ready, 1);
        ble_in = 6'b000001;
        load_cfg("after_abort", v_aaaa, 2'b00);
        check("after_abort_in01", ble_out, 2'b11);
        ble_in = 6'b111110;
        #1;
        check("after_abort_in3e", ble_out, 2'b00);

        // ---- back-to-back loads with valid held high ----
        stalls    = 0;
        done_seen = 0;
        cfg_valid = 1'b1;
        for (int w = 0; w < 18; w++) begin
            cur      = (w < 9) ? v_ones : v_cnt;
            cfg_data = cur[(w % 9)*8 +: 8];
            n = 0;
            while (!cfg_ready && n < 8) begin
                if (cfg_done) done_seen++;
                stalls++;
                tick();
                n++;
            end
            if (w == 9) begin
                check("b2b_stall_cycles", stalls, 1);
                check("b2b_first_done", done_seen, 1);
                $display("load b2b_first: committed cfg=%h", v_ones[66:0]);
            end
            tick();
            if (w == 12) begin
                ble_in = 6'b000000;
                #1;
                check("b2b_first_cfg_active", ble_out, 2'b11);
            end
        end
        check("b2b_second_done", cfg_done, 1);
        check("b2b_second_ready", cfg_ready, 0);
        check("b2b_total_stalls", stalls, 1);
        cfg_valid = 1'b0;
        tick();
        $display("load b2b_second: committed cfg=%h", v_cnt[66:0]);
        check("b2b_post_done", cfg_done, 0);
        ble_in = 6'd0;  #1; check("cnt_idx0", ble_out, 2'b11);
        ble_in = 6'd4;  #1; check("cnt_idx4", ble_out, 2'b00);
        ble_in = 6'd8;  #1; check("cnt_idx8", ble_out, 2'b11);
        ble_in = 6'd33; #1; check("cnt_idx33", ble_out, 2'b11);
        ble_in = 6'd56; #1; check("cnt_idx56", ble_out, 2'b11);
        ble_in = 6'd60; #1; check("cnt_idx60", ble_out, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ble_k_frac
